// File: rtl/esteira_sensor_cond.sv
// rtl/esteira_sensor_cond.sv - conveyor item sensor conditioner: sync, debounce, item pulse, jam detect
// Optional minimum-gap item filter is compiled in with `define MIN_GAP_EN.
module esteira_sensor_cond #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int DB_CYCLES  = 4,
  parameter int JAM_CYCLES = 16,
  parameter int MIN_GAP    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_raw,
  input  logic       en,
  input  logic       clr_jam,
  output logic       item,
  output logic       sensor_db,
  output logic       jam,
  output logic [3:0] reject_cnt
);

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);
  localparam logic [7:0] JAM_MAX = 8'(JAM_CYCLES);

  logic       sync1_q, sync2_q;
  logic       s;
  logic       sensor_db_q, sensor_db_d;
  logic [7:0] db_cnt_q, db_cnt_d;
  logic [7:0] jam_cnt_q, jam_cnt_d;
  logic       jam_q, jam_d;
  logic       item_q, item_d;
  logic       rise;
  logic       gap_ok;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sensor_raw;
      sync2_q <= sync1_q;
    end
  end

  // Normalized level: 1 always means the beam is blocked.
  assign s = sync2_q ^ ACTIVE_LOW;

  // Debounce: accept a new level only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    sensor_db_d = sensor_db_q;
    db_cnt_d    = 8'd0;
    if (s != sensor_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        sensor_db_d = s;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
    end
  end

  assign rise = sensor_db_d & ~sensor_db_q;

  // Jam: count consecutive blocked cycles; the flag is sticky and only clears once the beam is free.
  always_comb begin
    jam_cnt_d = 8'd0;
    if (sensor_db_q) begin
      jam_cnt_d = (jam_cnt_q == JAM_MAX) ? JAM_MAX : jam_cnt_q + 8'd1;
    end
    jam_d = jam_q;
    if (sensor_db_q && (jam_cnt_d == JAM_MAX)) begin
      jam_d = 1'b1;
    end else if (clr_jam && !sensor_db_q) begin
      jam_d = 1'b0;
    end
  end

`ifdef MIN_GAP_EN
  localparam logic [7:0] GAP_MAX = 8'(MIN_GAP);

  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [3:0] reject_cnt_q, reject_cnt_d;

  assign gap_ok = (gap_cnt_q >= GAP_MAX);

  // Gap filter: items closer than MIN_GAP cycles to the previous accepted one are rejected and counted.
  always_comb begin
    gap_cnt_d    = (gap_cnt_q >= GAP_MAX) ? GAP_MAX : gap_cnt_q + 8'd1;
    reject_cnt_d = reject_cnt_q;
    if (rise && en && gap_ok) begin
      gap_cnt_d = 8'd0;
    end
    if (rise && en && !gap_ok && (reject_cnt_q != 4'hF)) begin
      reject_cnt_d = reject_cnt_q + 4'd1;
    end
  end

  // Gap counter starts saturated so the first item after reset is always accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt_q    <= GAP_MAX;
      reject_cnt_q <= 4'd0;
    end else begin
      gap_cnt_q    <= gap_cnt_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign reject_cnt = reject_cnt_q;
`else
  assign gap_ok     = 1'b1;
  assign reject_cnt = 4'd0;
`endif

  // Item pulse lands on the same edge that sensor_db rises.
  always_comb begin
    item_d = rise & en & gap_ok;
  end

  // Main state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sensor_db_q <= 1'b0;
      db_cnt_q    <= 8'd0;
      jam_cnt_q   <= 8'd0;
      jam_q       <= 1'b0;
      item_q      <= 1'b0;
    end else begin
      sensor_db_q <= sensor_db_d;
      db_cnt_q    <= db_cnt_d;
      jam_cnt_q   <= jam_cnt_d;
      jam_q       <= jam_d;
      item_q      <= item_d;
    end
  end

  assign item      = item_q;
  assign sensor_db = sensor_db_q;
  assign jam       = jam_q;

endmodule

// File: tb/tb_esteira_sensor_cond.sv
// tb/tb_esteira_sensor_cond.sv - directed self-checking bench for esteira_sensor_cond
module tb_esteira_sensor_cond;

  logic       clk;
  logic       rst;
  logic       sensor_raw;
  logic       en;
  logic       clr_jam;
  logic       item;
  logic       sensor_db;
  logic       jam;
  logic [3:0] reject_cnt;

  int checks;
  int errors;
  int item_cnt;
  int base;

  esteira_sensor_cond dut (
    .clk        (clk),
    .rst        (rst),
    .sensor_raw (sensor_raw),
    .en         (en),
    .clr_jam    (clr_jam),
    .item       (item),
    .sensor_db  (sensor_db),
    .jam        (jam),
    .reject_cnt (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count item pulses away from the active edge.
  always @(negedge clk) begin
    if (item === 1'b1) item_cnt++;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sensor_raw = 1'b0; en = 1'b1; clr_jam = 1'b0;
    step(3);
    checks++; if (sensor_db !== 1'b0) begin errors++; $display("FAIL reset_sensor_db got=%b exp=0", sensor_db); end
    checks++; if (item !== 1'b0) begin errors++; $display("FAIL reset_item got=%b exp=0", item); end
    checks++; if (jam !== 1'b0) begin errors++; $display("FAIL reset_jam got=%b exp=0", jam); end
    checks++; if (reject_cnt !== 4'd0) begin errors++; $display("FAIL reset_reject got=%0d exp=0", reject_cnt); end
    rst = 1'b0;
    step(20);
  endtask

  task automatic test_clean_item;
    base = item_cnt;
    sensor_raw = 1'b1;
    step(5);
    checks++; if (sensor_db !== 1'b0) begin errors++; $display("FAIL clean_edge5_db got=%b exp=0", sensor_db); end
    step(1);
    checks++; if (sensor_db !== 1'b1) begin errors++; $display("FAIL clean_edge6_db got=%b exp=1", sensor_db); end
    checks++; if (item !== 1'b1) begin errors++; $display("FAIL clean_edge6_item got=%b exp=1", item); end
    step(1);
    checks++; if (item !== 1'b0) begin errors++; $display("FAIL clean_edge7_item got=%b exp=0", item); end
    step(3);
    sensor_raw = 1'b0;
    step(5);
    checks++; if (sensor_db !== 1'b1) begin errors++; $display("FAIL clean_fall5_db got=%b exp=1", sensor_db); end
    step(1);
    checks++; if (sensor_db !== 1'b0) begin errors++; $display("FAIL clean_fall6_db got=%b exp=0", sensor_db); end
    checks++; if (item !== 1'b0) begin errors++; $display("FAIL clean_fall6_item got=%b exp=0", item); end
    step(5);
    checks++; if ((item_cnt - base) !== 1) begin errors++; $display("FAIL clean_item_count got=%0d exp=1", item_cnt - base); end
    checks++; if (jam !== 1'b0) begin errors++; $display("FAIL clean_jam got=%b exp=0", jam); end
    step(20);
  endtask

  task automatic test_glitch;
    base = item_cnt;
    sensor_raw = 1'b1;
    step(3);
    sensor_raw = 1'b0;
    step(10);
    checks++; if (sensor_db !== 1'b0) begin errors++; $display("FAIL glitch_high_db got=%b exp=0", sensor_db); end
    checks++; if ((item_cnt - base) !== 0) begin errors++; $display("FAIL glitch_high_items got=%0d exp=0", item_cnt - base); end
    step(20);
    base = item_cnt;
    sensor_raw = 1'b1;
    step(7);
    sensor_raw = 1'b0;
    step(3);
    sensor_raw = 1'b1;
    step(3);
    checks++; if (sensor_db !== 1'b1) begin errors++; $display("FAIL glitch_low_db got=%b exp=1", sensor_db); end
    checks++; if ((item_cnt - base) !== 1) begin errors++; $display("FAIL glitch_low_items got=%0d exp=1", item_cnt - base); end
    sensor_raw = 1'b0;
    step(10);
    checks++; if (sensor_db !== 1'b0) begin errors++; $display("FAIL glitch_release_db got=%b exp=0", sensor_db); end
    step(20);
  endtask

  task automatic test_jam;
    base = item_cnt;
    sensor_raw = 1'b1;
    step(6);
    checks++; if (item !== 1'b1) begin errors++; $display("FAIL jam_item_edge6 got=%b exp=1", item); end
    step(15);
    checks++; if (jam !== 1'b0) begin errors++; $display("FAIL jam_edge21 got=%b exp=0", jam); end
    step(1);
    checks++; if (jam !== 1'b1) begin errors++; $display("FAIL jam_edge22 got=%b exp=1", jam); end
    step(2);
    clr_jam = 1'b1;
    step(1);
    clr_jam = 1'b0;
    checks++; if (jam !== 1'b1) begin errors++; $display("FAIL jam_clr_blocked got=%b exp=1", jam); end
    step(5);
    sensor_raw = 1'b0;
    step(6);
    checks++; if (sensor_db !== 1'b0) begin errors++; $display("FAIL jam_db_fall got=%b exp=0", sensor_db); end
    checks++; if (jam !== 1'b1) begin errors++; $display("FAIL jam_hold_free got=%b exp=1", jam); end
    clr_jam = 1'b1;
    step(1);
    clr_jam = 1'b0;
    checks++; if (jam !== 1'b0) begin errors++; $display("FAIL jam_clr_free got=%b exp=0", jam); end
    checks++; if ((item_cnt - base) !== 1) begin errors++; $display("FAIL jam_item_count got=%0d exp=1", item_cnt - base); end
    step(20);
  endtask

  task automatic test_enable;
    base = item_cnt;
    en = 1'b0;
    sensor_raw = 1'b1;
    step(6);
    checks++; if (sensor_db !== 1'b1) begin errors++; $display("FAIL en_db_rise got=%b exp=1", sensor_db); end
    checks++; if (item !== 1'b0) begin errors++; $display("FAIL en_item got=%b exp=0", item); end
    step(4);
    sensor_raw = 1'b0;
    step(10);
    checks++; if (sensor_db !== 1'b0) begin errors++; $display("FAIL en_db_fall got=%b exp=0", sensor_db); end
    checks++; if ((item_cnt - base) !== 0) begin errors++; $display("FAIL en_item_count got=%0d exp=0", item_cnt - base); end
    checks++; if (reject_cnt !== 4'd0) begin errors++; $display("FAIL en_reject got=%0d exp=0", reject_cnt); end
    en = 1'b1;
    step(20);
  endtask

  task automatic test_gap;
    int exp_items;
    int exp_rej;
`ifdef MIN_GAP_EN
    exp_items = 1; exp_rej = 1;
`else
    exp_items = 2; exp_rej = 0;
`endif
    base = item_cnt;
    sensor_raw = 1'b1;
    step(5);
    sensor_raw = 1'b0;
    step(5);
    sensor_raw = 1'b1;
    step(5);
    checks++; if (sensor_db !== 1'b0) begin errors++; $display("FAIL gap_edge15_db got=%b exp=0", sensor_db); end
    step(1);
    checks++; if (sensor_db !== 1'b1) begin errors++; $display("FAIL gap_edge16_db got=%b exp=1", sensor_db); end
    sensor_raw = 1'b0;
    step(15);
    checks++; if ((item_cnt - base) !== exp_items) begin errors++; $display("FAIL gap_items got=%0d exp=%0d", item_cnt - base, exp_items); end
    checks++; if (reject_cnt !== 4'(exp_rej)) begin errors++; $display("FAIL gap_reject got=%0d exp=%0d", reject_cnt, exp_rej); end
    step(20);
  endtask

  task automatic test_reset_mid;
    sensor_raw = 1'b1;
    step(25);
    checks++; if (jam !== 1'b1) begin errors++; $display("FAIL rstmid_jam_pre got=%b exp=1", jam); end
    rst = 1'b1;
    step(1);
    checks++; if (sensor_db !== 1'b0) begin errors++; $display("FAIL rstmid_db got=%b exp=0", sensor_db); end
    checks++; if (jam !== 1'b0) begin errors++; $display("FAIL rstmid_jam got=%b exp=0", jam); end
    checks++; if (item !== 1'b0) begin errors++; $display("FAIL rstmid_item got=%b exp=0", item); end
    checks++; if (reject_cnt !== 4'd0) begin errors++; $display("FAIL rstmid_reject got=%0d exp=0", reject_cnt); end
    rst = 1'b0;
    step(5);
    checks++; if (sensor_db !== 1'b0) begin errors++; $display("FAIL rstmid_edge5_db got=%b exp=0", sensor_db); end
    step(1);
    checks++; if (sensor_db !== 1'b1) begin errors++; $display("FAIL rstmid_edge6_db got=%b exp=1", sensor_db); end
    checks++; if (item !== 1'b1) begin errors++; $display("FAIL rstmid_edge6_item got=%b exp=1", item); end
    sensor_raw = 1'b0;
    step(10);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    item_cnt = 0;
    base = 0;
    test_reset();
    test_clean_item();
    test_glitch();
    test_jam();
    test_enable();
    test_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
